// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM read controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } rd_state_e;

    localparam int RD_HOLD = 2;
    localparam int RD_LAT  = 2;

    localparam int HOLD_W = (RD_HOLD > 1) ? $clog2(RD_HOLD) : 1;

    typedef logic [HOLD_W-1:0] hold_cnt_t;

endpackage

// File: rtl/bram_rd_ctrl_if.sv
// Request/response handshake bundle between a requester and bram_rd_ctrl.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel; BRAM_RD_PARITY_EN adds rsp_err.
interface bram_rd_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready;
`ifdef BRAM_RD_PARITY_EN
    logic          rsp_err;
`endif

    modport master (
        output req_valid, req_addr, rsp_ready,
`ifdef BRAM_RD_PARITY_EN
        input  rsp_err,
`endif
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
`ifdef BRAM_RD_PARITY_EN
        output rsp_err,
`endif
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/bram_rd_rsp_reg.sv
// Response holding register: captures BRAM data, presents it until taken, counts completed reads.
// Latency: 1 cycle from capture to rsp_valid.
// Backpressure: word held indefinitely while rsp_ready is low; BRAM_RD_PARITY_EN adds the rsp_err flag.
module bram_rd_rsp_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic [DW-1:0] rdata,
`ifdef BRAM_RD_PARITY_EN
    input  logic          rpar,
    output logic          rsp_err,
`endif
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [7:0]    rd_count
);

    // rsp_data deliberately survives the handshake; only a new capture replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rd_count  <= 8'd0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rdata;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rd_count  <= rd_count + 8'd1;
        end
    end

`ifdef BRAM_RD_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= (^rdata) != rpar;
        end
    end
`endif

endmodule

// File: rtl/bram_rd_ctrl.sv
// Single-outstanding BRAM read controller: rd held two cycles, data captured after the fixed read latency.
// Latency: request handshake to rsp_valid is 3 cycles.
// Backpressure: req_ready only in IDLE; RESP stretches while rsp_ready is low. BRAM_RD_PARITY_EN adds parity check.
module bram_rd_ctrl
    import bram_rd_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    bram_rd_ctrl_if.slave io,
    output logic          rd,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_rdata,
`ifdef BRAM_RD_PARITY_EN
    input  logic          bram_rpar,
`endif
    output logic          busy,
    output logic [7:0]    rd_count
);

    rd_state_e state;
    hold_cnt_t hold_cnt;
    logic      capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            bram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.req_valid) begin
                        bram_addr <= io.req_addr;
                        hold_cnt  <= '0;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (hold_cnt == hold_cnt_t'(RD_HOLD - 1)) begin
                        state <= WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + hold_cnt_t'(1);
                    end
                end
                WAIT: state <= RESP;
                RESP: begin
                    if (io.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the async-reset state so rd drops the moment rst rises.
    assign rd           = (state == RD);
    assign busy         = (state != IDLE);
    assign capture      = (state == WAIT);
    assign io.req_ready = (state == IDLE) && !rst;

    bram_rd_rsp_reg #(
        .DW (DW)
    ) u_rsp_reg (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .rdata     (bram_rdata),
`ifdef BRAM_RD_PARITY_EN
        .rpar      (bram_rpar),
        .rsp_err   (io.rsp_err),
`endif
        .rsp_ready (io.rsp_ready),
        .rsp_valid (io.rsp_valid),
        .rsp_data  (io.rsp_data),
        .rd_count  (rd_count)
    );

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// Scoreboard bench for bram_rd_ctrl with a two-cycle-latency BRAM model.
// BRAM_RD_PARITY_EN enables the parity section.
module tb_bram_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd;
    logic [7:0] bram_addr;
    logic [7:0] bram_rdata = 8'd0;
    logic       busy;
    logic [7:0] rd_count;
`ifdef BRAM_RD_PARITY_EN
    logic       par_flip = 1'b0;
    logic       bram_rpar;
    assign bram_rpar = (^bram_rdata) ^ par_flip;
`endif

    always #5 clk = ~clk;

    bram_rd_ctrl_if #(.AW(8), .DW(8)) io();

    bram_rd_ctrl #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .rd         (rd),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
`ifdef BRAM_RD_PARITY_EN
        .bram_rpar  (bram_rpar),
`endif
        .busy       (busy),
        .rd_count   (rd_count)
    );

    // BRAM model: address sampled while rd is high, data out two edges later.
    logic [7:0] mem [256];
    logic [7:0] p1 = 8'd0;
    always @(posedge clk) begin
        if (rd) p1 <= mem[bram_addr];
        bram_rdata <= p1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [7:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && io.rsp_valid && io.rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", io.rsp_data, e.data);
`ifdef BRAM_RD_PARITY_EN
                check("rsp_err", io.rsp_err, e.err);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic single_req(input logic [7:0] a, input logic [7:0] d, input logic e);
        io.req_valid = 1'b1;
        io.req_addr  = a;
        push_exp(d, e);
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    logic [7:0] b2b_addr [3];
    int lows;
    int start_cnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h12] = 8'hA5;
        mem[8'h30] = 8'h03;
        b2b_addr[0] = 8'h01;
        b2b_addr[1] = 8'h02;
        b2b_addr[2] = 8'h03;

        rst          = 1'b1;
        io.req_valid = 1'b0;
        io.req_addr  = 8'h00;
        io.rsp_ready = 1'b1;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", io.req_ready, 1'b0);
        check("rst_rd", rd, 1'b0);
        check("rst_rsp_valid", io.rsp_valid, 1'b0);
        check("rst_rsp_data", io.rsp_data, 8'h00);
        check("rst_bram_addr", bram_addr, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_count", rd_count, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_req_ready", io.req_ready, 1'b1);
        check("rel_rd", rd, 1'b0);
        check("rel_rsp_valid", io.rsp_valid, 1'b0);

        // Single read, cycle by cycle
        io.req_valid = 1'b1;
        io.req_addr  = 8'h12;
        push_exp(8'hA5, 1'b0);
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        @(negedge clk);
        check("s_rd_c1", rd, 1'b1);
        check("s_addr_c1", bram_addr, 8'h12);
        check("s_busy", busy, 1'b1);
        check("s_req_ready_busy", io.req_ready, 1'b0);
        @(negedge clk);
        check("s_rd_c2", rd, 1'b1);
        check("s_addr_c2", bram_addr, 8'h12);
        @(negedge clk);
        check("s_rd_wait", rd, 1'b0);
        check("s_rsp_valid_wait", io.rsp_valid, 1'b0);
        @(negedge clk);
        check("s_rsp_valid_e3", io.rsp_valid, 1'b1);
        check("s_rd_resp", rd, 1'b0);
        @(negedge clk);
        check("s_rd_count", rd_count, 8'd1);
        check("s_req_ready_e4", io.req_ready, 1'b1);
        check("s_rsp_valid_done", io.rsp_valid, 1'b0);
        check("s_rsp_data_held", io.rsp_data, 8'hA5);

        // Back-pressure for five cycles
        @(posedge clk);
        #1 io.rsp_ready = 1'b0;
        io.req_valid = 1'b1;
        io.req_addr  = 8'h20;
        push_exp(8'h7A, 1'b0);
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", io.rsp_valid, 1'b1);
            check("bp_rsp_data", io.rsp_data, 8'h7A);
            check("bp_req_ready", io.req_ready, 1'b0);
            check("bp_rd", rd, 1'b0);
        end
        @(posedge clk);
        #1 io.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_idle_ready", io.req_ready, 1'b1);
        check("bp_idle_busy", busy, 1'b0);
        check("bp_rd_count", rd_count, 8'd2);

        // Back-to-back with req_valid held high
        io.req_valid = 1'b1;
        io.req_addr  = b2b_addr[0];
        push_exp(8'h5B, 1'b0);
        push_exp(8'h58, 1'b0);
        push_exp(8'h59, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                lows = 0;
                @(negedge clk);
                while (!io.req_ready && lows < 20) begin
                    lows++;
                    @(negedge clk);
                end
                check("b2b_gap_low_cycles", lows, 4);
                io.req_addr = b2b_addr[i];
            end
            @(posedge clk);
        end
        #1 io.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_rd_count", rd_count, 8'd5);
        check("b2b_req_ready", io.req_ready, 1'b1);

        // Reset during the second RD cycle
        io.req_valid = 1'b1;
        io.req_addr  = 8'h40;
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        @(posedge clk);
        #1 check("mr_rd_before", rd, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mr_rd_async", rd, 1'b0);
        check("mr_rsp_valid", io.rsp_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_rd_count", rd_count, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_cnt = checks;
        repeat (3) begin
            @(negedge clk);
            check("mr_no_rsp", io.rsp_valid, 1'b0);
        end
        check("mr_rel_ready", io.req_ready, 1'b1);
        check("mr_rel_count", rd_count, 8'd0);
        single_req(8'h12, 8'hA5, 1'b0);
        check("mr_next_count", rd_count, 8'd1);

`ifdef BRAM_RD_PARITY_EN
        par_flip = 1'b1;
        single_req(8'h30, 8'h03, 1'b1);
        par_flip = 1'b0;
        single_req(8'h30, 8'h03, 1'b0);
        check("par_rd_count", rd_count, 8'd3);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
